controle_gerador_jogadas: RTL and testbench
===========================================

Name: controle_gerador_jogadas

Overview:
Sequencer that drives the random move generator: pulses its request line, waits out its latency, and samples row/column twice (origin, then destination).
- Rejects out-of-board or degenerate squares and re-requests until a legal pair is found or the retry budget runs out.
- Presents the finished move to the game FSM with a valid/accept handshake.
- Sits between the game-control FSM and the generator.

Parameters:
LATENCIA_GERADOR, 1, cycles after the novaJogada edge before generator outputs are sampled (>=1)
MAX_TENTATIVAS, 16, total generator requests allowed per move, origin and destination combined (2..255)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
iniciar  in  1  start request, sampled only in OCIOSO
aceito  in  1  consumer accepts the presented move
linha  in  4  generator row
coluna  in  4  generator column
novaJogada  out  1  request pulse to generator
origem_linha  out  4  accepted origin row
origem_coluna  out  4  accepted origin column
destino_linha  out  4  accepted destination row
destino_coluna  out  4  accepted destination column
valido  out  1  move available
erro  out  1  one-cycle pulse: retry budget exhausted
ocupado  out  1  high in every state except OCIOSO
tentativas  out  8  requests issued for current move

Behaviour:
- Reset (async, reset_n=0): state OCIOSO; every output 0; retry and latency counters 0. Reset mid-sequence aborts immediately, and novaJogada drops asynchronously.
- States: OCIOSO, PEDE_ORIG, ESPERA_ORIG, PEDE_DEST, ESPERA_DEST, PRONTO, ERRO.
- OCIOSO:
  - iniciar=1 -> PEDE_ORIG; clear tentativas and coordinate registers.
  - iniciar in any other state is ignored.
- PEDE_x (exactly 1 cycle): novaJogada=1, decoded from the state register; tentativas increments. Next state is ESPERA_x with the latency counter loaded to LATENCIA_GERADOR-1.
- ESPERA_x: lasts LATENCIA_GERADOR cycles. On the last cycle, linha/coluna are checked combinationally.
- Square legal iff 1<=linha<=8 and 1<=coluna<=8.
- Destination additionally illegal if equal to the latched origin (both fields equal).
- ESPERA_ORIG, legal -> latch origin, PEDE_DEST.
- ESPERA_DEST, legal -> latch destination, PRONTO.
- Illegal square:
  - tentativas==MAX_TENTATIVAS -> ERRO.
  - Otherwise -> PEDE_x of the same phase. Origin is kept while retrying destination.
- Minimum latency, iniciar to valido, with LATENCIA_GERADOR=1: 5 cycles (OCIOSO->PEDE_ORIG->ESPERA_ORIG->PEDE_DEST->ESPERA_DEST->PRONTO).
- PRONTO:
  - valido=1; coordinates stable.
  - aceito=1 -> OCIOSO; valido drops next cycle and coordinates hold until the next iniciar.
  - aceito outside PRONTO is ignored.
- ERRO: erro=1 for one cycle -> OCIOSO. Coordinates invalid; valido stays 0.
- The tentativas counter saturates at 255 and never wraps.

Optional Feature:
Macro MAPA_OCUPACAO_EN.
- Defined:
  - Extra input ocupacao[63:0] (bit index = (linha-1)*8 + (coluna-1)).
  - Origin additionally requires its bit = 1 (own piece present).
  - Destination additionally requires its bit = 0.
  - ocupacao is sampled on the same cycle as linha/coluna.
- Undefined: port absent; only range and origin!=destination checks apply.

Decomposition:
- Shared package xadrez_pkg:
  - state enum encoding
  - LINHA_MIN=1, LINHA_MAX=8, COLUNA_MIN=1, COLUNA_MAX=8
  - coordinate width 4
  - casa_index function (row/col -> 0..63)
- One natural sub-module, validador_casa: combinational legality check. Inputs: linha, coluna, origem, fase, and ocupacao when enabled. Output: legal.

Test Plan:
Directed tests drive linha/coluna from a scripted stub, not the real random generator.
- Reset: hold reset_n=0 mid-ESPERA_DEST -> all outputs 0 immediately, state OCIOSO; iniciar after release starts cleanly.
- Happy path: LATENCIA=1, stub returns (2,5) then (4,5) -> exactly 2 novaJogada pulses; valido at cycle 5 with origin (2,5), dest (4,5), tentativas=2.
- Retries: stub returns (0,3), (9,1), (3,3), (3,3), (6,7) -> 2 origin retries, 1 destination retry (equal square); result origin (3,3), dest (6,7), tentativas=5.
- Exhaustion: MAX_TENTATIVAS=4, stub always returns (0,0) -> 4 pulses, one-cycle erro, valido never set, back to OCIOSO.
- Handshake: hold aceito=0 for 10 cycles in PRONTO -> valido and coordinates stable; iniciar pulses ignored. aceito=1 -> valido=0 on the next cycle.
- MAPA_OCUPACAO_EN: ocupacao=only bit 9 set; stub returns (1,1), (2,2), (2,2), (3,3) -> origin rejected at (1,1); result origin (2,2) (idx 9), dest (3,3).

Source files
------------

// File: rtl/xadrez_pkg.sv
// Shared board constants, FSM encoding and square indexing for the move sequencer.
// MAPA_OCUPACAO_EN enables the occupancy-map checks that use casa_index.
package xadrez_pkg;

    localparam int COORD_W = 4;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t LINHA_MIN  = 4'd1;
    localparam coord_t LINHA_MAX  = 4'd8;
    localparam coord_t COLUNA_MIN = 4'd1;
    localparam coord_t COLUNA_MAX = 4'd8;

    localparam logic [2:0] OCIOSO      = 3'd0;
    localparam logic [2:0] PEDE_ORIG   = 3'd1;
    localparam logic [2:0] ESPERA_ORIG = 3'd2;
    localparam logic [2:0] PEDE_DEST   = 3'd3;
    localparam logic [2:0] ESPERA_DEST = 3'd4;
    localparam logic [2:0] PRONTO      = 3'd5;
    localparam logic [2:0] ERRO        = 3'd6;

    // Only meaningful for in-range squares (1..8 on both axes).
    function automatic logic [5:0] casa_index(input coord_t l, input coord_t c);
        coord_t lm;
        coord_t cm;
        lm = l - 4'd1;
        cm = c - 4'd1;
        return {lm[2:0], cm[2:0]};
    endfunction

endpackage

// File: rtl/controle_gerador_jogadas_if.sv
// Bundle between sequencer, move generator and game FSM.
// MAPA_OCUPACAO_EN adds the ocupacao board map.
interface controle_gerador_jogadas_if;
    import xadrez_pkg::*;

    logic        iniciar;
    logic        aceito;
    coord_t      linha;
    coord_t      coluna;
`ifdef MAPA_OCUPACAO_EN
    logic [63:0] ocupacao;
`endif
    logic        novaJogada;
    coord_t      origem_linha;
    coord_t      origem_coluna;
    coord_t      destino_linha;
    coord_t      destino_coluna;
    logic        valido;
    logic        erro;
    logic        ocupado;
    logic [7:0]  tentativas;

    modport master (
        input  iniciar, aceito, linha, coluna,
`ifdef MAPA_OCUPACAO_EN
        input  ocupacao,
`endif
        output novaJogada, origem_linha, origem_coluna,
        output destino_linha, destino_coluna,
        output valido, erro, ocupado, tentativas
    );

    modport slave (
        output iniciar, aceito, linha, coluna,
`ifdef MAPA_OCUPACAO_EN
        output ocupacao,
`endif
        input  novaJogada, origem_linha, origem_coluna,
        input  destino_linha, destino_coluna,
        input  valido, erro, ocupado, tentativas
    );

endinterface

// File: rtl/controle_gerador_jogadas_validador.sv
// Combinational legality check of one generated square.
// MAPA_OCUPACAO_EN adds the own-piece / empty-target rule.
module validador_casa
    import xadrez_pkg::*;
(
    input  coord_t      linha,
    input  coord_t      coluna,
    input  coord_t      origem_linha,
    input  coord_t      origem_coluna,
    input  logic        fase,
`ifdef MAPA_OCUPACAO_EN
    input  logic [63:0] ocupacao,
`endif
    output logic        legal
);

    logic na_faixa;
    logic repetida;
    logic mapa_ok;

    always_comb begin
        na_faixa = (linha >= LINHA_MIN) && (linha <= LINHA_MAX) &&
                   (coluna >= COLUNA_MIN) && (coluna <= COLUNA_MAX);
        repetida = fase && (linha == origem_linha) &&
                   (coluna == origem_coluna);
`ifdef MAPA_OCUPACAO_EN
        // fase=0: origin needs own piece; fase=1: target must be empty
        mapa_ok = ocupacao[casa_index(linha, coluna)] ^ fase;
`else
        mapa_ok = 1'b1;
`endif
        legal = na_faixa && !repetida && mapa_ok;
    end

endmodule

// File: rtl/controle_gerador_jogadas.sv
// Drives the random move generator, filters illegal squares and hands out moves.
// MAPA_OCUPACAO_EN adds occupancy-map filtering through validador_casa.
module controle_gerador_jogadas
    import xadrez_pkg::*;
#(
    parameter int LATENCIA_GERADOR = 1,
    parameter int MAX_TENTATIVAS   = 16
) (
    input  logic clock,
    input  logic reset_n,
    controle_gerador_jogadas_if.master bus
);

    localparam logic [15:0] ESPERA_INI = 16'(LATENCIA_GERADOR - 1);
    localparam logic [7:0]  MAX_T      = 8'(MAX_TENTATIVAS);

    logic [2:0]  estado;
    logic [15:0] espera;
    logic [7:0]  tentativas_q;
    coord_t      ol;
    coord_t      oc;
    coord_t      dl;
    coord_t      dc;
    logic        legal;
    logic        fim_espera;
    logic        esgotado;

    validador_casa u_validador (
        .linha         (bus.linha),
        .coluna        (bus.coluna),
        .origem_linha  (ol),
        .origem_coluna (oc),
        .fase          (estado == ESPERA_DEST),
`ifdef MAPA_OCUPACAO_EN
        .ocupacao      (bus.ocupacao),
`endif
        .legal         (legal)
    );

    assign fim_espera = (espera == 16'd0);
    assign esgotado   = (tentativas_q == MAX_T);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= OCIOSO;
            espera       <= 16'd0;
            tentativas_q <= 8'd0;
            ol           <= '0;
            oc           <= '0;
            dl           <= '0;
            dc           <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        estado       <= PEDE_ORIG;
                        tentativas_q <= 8'd0;
                        ol           <= '0;
                        oc           <= '0;
                        dl           <= '0;
                        dc           <= '0;
                    end
                end
                PEDE_ORIG, PEDE_DEST: begin
                    if (tentativas_q != 8'hFF)
                        tentativas_q <= tentativas_q + 8'd1;
                    espera <= ESPERA_INI;
                    estado <= (estado == PEDE_ORIG) ? ESPERA_ORIG
                                                    : ESPERA_DEST;
                end
                ESPERA_ORIG, ESPERA_DEST: begin
                    if (!fim_espera) begin
                        espera <= espera - 16'd1;
                    end else if (legal) begin
                        if (estado == ESPERA_ORIG) begin
                            ol     <= bus.linha;
                            oc     <= bus.coluna;
                            estado <= PEDE_DEST;
                        end else begin
                            dl     <= bus.linha;
                            dc     <= bus.coluna;
                            estado <= PRONTO;
                        end
                    end else if (esgotado) begin
                        estado <= ERRO;
                    end else begin
                        estado <= (estado == ESPERA_ORIG) ? PEDE_ORIG
                                                          : PEDE_DEST;
                    end
                end
                PRONTO: begin
                    if (bus.aceito)
                        estado <= OCIOSO;
                end
                ERRO:    estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

    // Decoded from the state so reset removes the request at once
    assign bus.novaJogada     = (estado == PEDE_ORIG) || (estado == PEDE_DEST);
    assign bus.valido         = (estado == PRONTO);
    assign bus.erro           = (estado == ERRO);
    assign bus.ocupado        = (estado != OCIOSO);
    assign bus.tentativas     = tentativas_q;
    assign bus.origem_linha   = ol;
    assign bus.origem_coluna  = oc;
    assign bus.destino_linha  = dl;
    assign bus.destino_coluna = dc;

endmodule

// File: tb/tb_controle_gerador_jogadas.sv
// Bench: two sequencers (lat 1 / max 16, lat 3 / max 4) fed by scripted generator stubs.
// Expected moves come from a transaction-level model of the legality rules.
module tb_controle_gerador_jogadas;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int LAT [2] = '{1, 3};
    int MX  [2] = '{16, 4};

    logic        ini [2];
    logic        ace [2];
    logic [3:0]  lin [2];
    logic [3:0]  col [2];
    logic [63:0] occ [2];
    logic        nj  [2];
    logic        vld [2];
    logic        er  [2];
    logic        ocp [2];
    logic [7:0]  tent [2];
    logic [3:0]  ol [2];
    logic [3:0]  oc [2];
    logic [3:0]  dl [2];
    logic [3:0]  dc [2];

    logic [3:0] sl [2][1024];
    logic [3:0] sc [2][1024];
    int         ptr [2] = '{0, 0};

    int checks = 0;
    int errors = 0;

    controle_gerador_jogadas_if bus_a ();
    controle_gerador_jogadas_if bus_b ();

    controle_gerador_jogadas #(.LATENCIA_GERADOR(1), .MAX_TENTATIVAS(16)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a));
    controle_gerador_jogadas #(.LATENCIA_GERADOR(3), .MAX_TENTATIVAS(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b));

    assign bus_a.iniciar = ini[0];
    assign bus_a.aceito  = ace[0];
    assign bus_a.linha   = lin[0];
    assign bus_a.coluna  = col[0];
    assign bus_b.iniciar = ini[1];
    assign bus_b.aceito  = ace[1];
    assign bus_b.linha   = lin[1];
    assign bus_b.coluna  = col[1];
`ifdef MAPA_OCUPACAO_EN
    assign bus_a.ocupacao = occ[0];
    assign bus_b.ocupacao = occ[1];
`endif
    assign nj[0]   = bus_a.novaJogada;
    assign vld[0]  = bus_a.valido;
    assign er[0]   = bus_a.erro;
    assign ocp[0]  = bus_a.ocupado;
    assign tent[0] = bus_a.tentativas;
    assign ol[0]   = bus_a.origem_linha;
    assign oc[0]   = bus_a.origem_coluna;
    assign dl[0]   = bus_a.destino_linha;
    assign dc[0]   = bus_a.destino_coluna;
    assign nj[1]   = bus_b.novaJogada;
    assign vld[1]  = bus_b.valido;
    assign er[1]   = bus_b.erro;
    assign ocp[1]  = bus_b.ocupado;
    assign tent[1] = bus_b.tentativas;
    assign ol[1]   = bus_b.origem_linha;
    assign oc[1]   = bus_b.origem_coluna;
    assign dl[1]   = bus_b.destino_linha;
    assign dc[1]   = bus_b.destino_coluna;

    // Generator stub: each request pulse presents the next scripted square
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (nj[k]) begin
                lin[k] = sl[k][ptr[k] % 1024];
                col[k] = sc[k][ptr[k] % 1024];
                ptr[k] = ptr[k] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int k, input int i, input int l, input int c);
        sl[k][(ptr[k] + i) % 1024] = 4'(l);
        sc[k][(ptr[k] + i) % 1024] = 4'(c);
    endtask

    // Walks the script with the board rules; n = requests consumed
    function automatic void modelo(input int k, input int base, input int mx,
                                   input logic [63:0] mapa, output int n,
                                   output bit ok, output int eol, output int eoc,
                                   output int edl, output int edc);
        int l, c;
        bit fase, bom;
        n = 0; ok = 0; fase = 0;
        eol = 0; eoc = 0; edl = 0; edc = 0;
        for (int i = 0; i < 256; i++) begin
            l = int'(sl[k][(base + n) % 1024]);
            c = int'(sc[k][(base + n) % 1024]);
            n++;
            bom = (l >= 1 && l <= 8 && c >= 1 && c <= 8);
            if (fase && l == eol && c == eoc) bom = 0;
`ifdef MAPA_OCUPACAO_EN
            if (bom && fase == mapa[(l - 1) * 8 + (c - 1)]) bom = 0;
`else
            if (mapa[0] && 1'b0) bom = 0;
`endif
            if (bom && !fase) begin
                eol = l; eoc = c; fase = 1;
            end else if (bom) begin
                edl = l; edc = c; ok = 1;
                return;
            end else if (n == mx) begin
                return;
            end
        end
    endfunction

    task automatic transacao(input int k, input logic [63:0] mapa,
                             input string tag);
        int n, cyc, base, eol, eoc, edl, edc;
        bit ok, estavel;
        base = ptr[k];
        modelo(k, base, MX[k], mapa, n, ok, eol, eoc, edl, edc);
        @(negedge clock);
        occ[k] = mapa;
        ini[k] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            ini[k] = 1'b0;
        end while (!vld[k] && !er[k] && cyc < 2000);
        chk({tag, " latencia"}, 64'(cyc), 64'(n * (1 + LAT[k]) + 1));
        chk({tag, " valido"}, 64'(vld[k]), 64'(ok));
        chk({tag, " erro"}, 64'(er[k]), 64'(!ok));
        chk({tag, " pulsos"}, 64'(ptr[k] - base), 64'(n));
        chk({tag, " tentativas"}, 64'(tent[k]), 64'(n));
        if (ok) begin
            chk({tag, " origem"}, {56'd0, ol[k], oc[k]}, 64'(eol * 16 + eoc));
            chk({tag, " destino"}, {56'd0, dl[k], dc[k]}, 64'(edl * 16 + edc));
            estavel = 1;
            for (int i = 0; i < 10; i++) begin
                ini[k] = 1'(i % 2);
                @(negedge clock);
                if (!vld[k] || ol[k] != 4'(eol) || oc[k] != 4'(eoc) ||
                    dl[k] != 4'(edl) || dc[k] != 4'(edc) || nj[k])
                    estavel = 0;
            end
            ini[k] = 1'b0;
            chk({tag, " espera aceito"}, 64'(estavel), 64'd1);
            ace[k] = 1'b1;
            @(negedge clock);
            ace[k] = 1'b0;
            chk({tag, " valido apos aceito"}, 64'(vld[k]), 64'd0);
            chk({tag, " ocupado apos aceito"}, 64'(ocp[k]), 64'd0);
            chk({tag, " coord mantidas"}, {48'd0, ol[k], oc[k], dl[k], dc[k]},
                64'((eol << 12) | (eoc << 8) | (edl << 4) | edc));
        end else begin
            @(negedge clock);
            chk({tag, " erro um ciclo"}, 64'(er[k]), 64'd0);
            chk({tag, " ocioso apos erro"}, 64'(ocp[k]), 64'd0);
            chk({tag, " sem valido"}, 64'(vld[k]), 64'd0);
        end
    endtask

    task automatic zero_saidas(input int k, input string tag);
        chk(tag, {nj[k], vld[k], er[k], ocp[k], tent[k],
                  ol[k], oc[k], dl[k], dc[k]}, 64'd0);
    endtask

    initial begin
        int k, vistos, cyc;
        logic [63:0] mapa;
        for (int j = 0; j < 2; j++) begin
            ini[j] = 0; ace[j] = 0; occ[j] = '0;
            lin[j] = 0; col[j] = 0;
        end
        for (int j = 0; j < 1024; j++) begin
            sl[0][j] = 0; sc[0][j] = 0; sl[1][j] = 0; sc[1][j] = 0;
        end
        repeat (3) @(negedge clock);
        zero_saidas(0, "reset a");
        zero_saidas(1, "reset b");
        reset_n = 1'b1;

        put(0, 0, 2, 5); put(0, 1, 4, 5);
        transacao(0, '0, "feliz");

        put(0, 0, 0, 3); put(0, 1, 9, 1); put(0, 2, 3, 3);
        put(0, 3, 3, 3); put(0, 4, 6, 7);
        transacao(0, '0, "retentativas");

        for (int i = 0; i < 8; i++) put(1, i, 0, 0);
        transacao(1, '0, "esgotado");

        // Reset while the destination request is on the wire
        put(1, 0, 5, 5); put(1, 1, 6, 6);
        @(negedge clock);
        occ[1] = 64'hFFFF_FFFF_0000_0000;
        ini[1] = 1'b1;
        vistos = 0; cyc = 0;
        do begin
            @(negedge clock);
            ini[1] = 1'b0;
            cyc++;
            if (nj[1]) vistos++;
        end while (vistos < 2 && cyc < 200);
        chk("reset pede_dest", 64'(vistos), 64'd2);
        #1 reset_n = 1'b0;
        #1 zero_saidas(1, "reset assincrono");
        @(negedge clock);
        reset_n = 1'b1;
        put(1, 0, 7, 2); put(1, 1, 7, 3);
        transacao(1, 64'h0000_0000_0000_4000, "apos reset");

`ifdef MAPA_OCUPACAO_EN
        put(0, 0, 1, 1); put(0, 1, 2, 2); put(0, 2, 2, 2); put(0, 3, 3, 3);
        transacao(0, 64'h0000_0000_0000_0200, "mapa");
`endif

        for (int t = 0; t < 24; t++) begin
            k = int'($urandom_range(0, 1));
            for (int i = 0; i < 20; i++) begin
                if ($urandom_range(0, 3) == 0)
                    put(k, i, int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 15)));
                else
                    put(k, i, int'($urandom_range(1, 3)),
                        int'($urandom_range(1, 3)));
            end
            mapa = {$urandom, $urandom};
            transacao(k, mapa, "aleatorio");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
